// File: rtl/prco_boot_loader.sv
// UART program loader for prco_core: receives a framed image,
// writes it into core memory, then releases the core with a reset pulse.
module prco_boot_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          MEM_DEPTH    = 256,
  parameter int          TIMEOUT_CLKS = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx,
  output logic        q_mem_we,
  output logic [15:0] q_mem_addr,
  output logic [15:0] q_mem_dat,
  output logic        q_core_hold,
  output logic        q_core_reset,
  output logic        q_done,
  output logic        q_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] SYNC = 8'hA5;

  localparam logic [1:0] RX_WAIT_START = 2'd0;
  localparam logic [1:0] RX_START      = 2'd1;
  localparam logic [1:0] RX_DATA       = 2'd2;
  localparam logic [1:0] RX_STOP       = 2'd3;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CSUM    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_RUN     = 4'd8;
  localparam logic [3:0] S_ERROR   = 4'd9;

  logic          rx_s1, rx_s2;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bitn;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_ferr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_state <= RX_WAIT_START;
      rx_cnt   <= '0;
      rx_bitn  <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_WAIT_START: begin
          rx_cnt <= '0;
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == HALF_LAST) begin
            rx_cnt  <= '0;
            rx_bitn <= '0;
            // High at mid-start means a glitch, not a real start bit
            rx_state <= rx_s2 ? RX_WAIT_START : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bitn  <= rx_bitn + 1'b1;
            if (rx_bitn == 3'd7) rx_state <= RX_STOP;
          end
        end
        default: begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_byte  <= rx_shift;
            rx_valid <= rx_s2;
            rx_ferr  <= !rx_s2;
            rx_state <= RX_WAIT_START;
          end
        end
      endcase
    end
  end

  logic [3:0]    state;
  logic [TW-1:0] tcnt;
  logic [7:0]    len_hi;
  logic [7:0]    data_hi;
  logic [7:0]    sum;
  logic [15:0]   remaining;
  logic          hold_q;
  logic          in_frame;
  logic          timeout;
  logic          ferr_hit;
  logic          sync_hit;
  logic [15:0]   len_w;

  assign in_frame = (state >= S_LEN_HI) && (state <= S_CSUM);
  assign timeout  = in_frame && !rx_valid && (tcnt >= TW'(TIMEOUT_CLKS));
  assign ferr_hit = rx_ferr && (state != S_IDLE) && (state != S_RUN);
  assign sync_hit = rx_valid && (rx_byte == SYNC);
  assign len_w    = {len_hi, rx_byte};

  // Hold must rise on the very cycle a re-sync byte is accepted in RUN
  assign q_core_hold = hold_q || ((state == S_RUN) && sync_hit);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      tcnt         <= '0;
      len_hi       <= '0;
      data_hi      <= '0;
      sum          <= '0;
      remaining    <= '0;
      hold_q       <= 1'b1;
      q_mem_we     <= 1'b0;
      q_mem_addr   <= BASE_ADDR;
      q_mem_dat    <= '0;
      q_core_reset <= 1'b0;
      q_done       <= 1'b0;
      q_err        <= 1'b0;
    end else begin
      q_mem_we     <= 1'b0;
      q_core_reset <= 1'b0;
      if (rx_valid) tcnt <= '0;
      else if (tcnt != '1) tcnt <= tcnt + 1'b1;

      if (ferr_hit || timeout) begin
        state  <= S_ERROR;
        q_err  <= 1'b1;
        hold_q <= 1'b1;
        q_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_RUN: begin
            if (sync_hit) begin
              state      <= S_LEN_HI;
              hold_q     <= 1'b1;
              q_err      <= 1'b0;
              q_done     <= 1'b0;
              q_mem_addr <= BASE_ADDR;
              sum        <= '0;
            end
          end
          S_LEN_HI: begin
            if (rx_valid) begin
              len_hi <= rx_byte;
              sum    <= sum + rx_byte;
              state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (rx_valid) begin
              sum       <= sum + rx_byte;
              remaining <= len_w;
              if (32'(len_w) > MEM_DEPTH) begin
                state <= S_ERROR;
                q_err <= 1'b1;
              end else if (len_w == 16'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA_HI;
              end
            end
          end
          S_DATA_HI: begin
            if (rx_valid) begin
              data_hi <= rx_byte;
              sum     <= sum + rx_byte;
              state   <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            if (rx_valid) begin
              sum       <= sum + rx_byte;
              q_mem_we  <= 1'b1;
              q_mem_dat <= {data_hi, rx_byte};
              state     <= S_WRITE;
            end
          end
          S_WRITE: begin
            q_mem_addr <= q_mem_addr + 16'd1;
            remaining  <= remaining - 16'd1;
            state      <= (remaining == 16'd1) ? S_CSUM : S_DATA_HI;
          end
          S_CSUM: begin
            if (rx_valid) begin
              if (rx_byte == sum) begin
                state        <= S_DONE;
                q_core_reset <= 1'b1;
                hold_q       <= 1'b0;
                q_done       <= 1'b1;
              end else begin
                state <= S_ERROR;
                q_err <= 1'b1;
              end
            end
          end
          S_DONE:  state <= S_RUN;
          S_ERROR: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prco_boot_loader.sv
// Bench for prco_boot_loader: frame table plus hand-written corner
// sequences, with memory writes checked against a scoreboard queue.
module tb_prco_boot_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_dat;
  logic        core_hold;
  logic        core_reset;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int core_resets = 0;
  logic [31:0] sb[$];

  prco_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR(16'h0000),
    .MEM_DEPTH(256),
    .TIMEOUT_CLKS(50)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_rx(rx),
    .q_mem_we(mem_we),
    .q_mem_addr(mem_addr),
    .q_mem_dat(mem_dat),
    .q_core_hold(core_hold),
    .q_core_reset(core_reset),
    .q_done(done),
    .q_err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && core_reset) core_resets++;
    if (!rst && mem_we) begin
      logic [31:0] exp;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected addr=%h dat=%h", mem_addr, mem_dat);
      end else begin
        exp = sb.pop_front();
        if ({mem_addr, mem_dat} !== exp) begin
          errors++;
          $display("FAIL write: got %h expected %h", {mem_addr, mem_dat}, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic expect_state(input string tag, input logic e_err,
                              input logic e_done, input int base_resets);
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_done"}, 32'(done), 32'(e_done));
    chk({tag, "_hold"}, 32'(core_hold), 32'(!e_done));
    chk({tag, "_core_reset_pulses"}, 32'(core_resets - base_resets),
        e_done ? 32'd1 : 32'd0);
    chk({tag, "_writes_left"}, 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  b[8];
    int          n;
    logic        err;
    logic        done;
    int          nw;
    logic [31:0] w[2];
  } vec_t;

  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit seen;

    tbl[0].name = "good2";
    tbl[0].b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    tbl[0].n = 8; tbl[0].err = 0; tbl[0].done = 1; tbl[0].nw = 2;
    tbl[0].w = '{32'h0000_1234, 32'h0001_ABCD};
    tbl[1].name = "badsum";
    tbl[1].b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
    tbl[1].n = 8; tbl[1].err = 1; tbl[1].done = 0; tbl[1].nw = 2;
    tbl[1].w = '{32'h0000_1234, 32'h0001_ABCD};
    tbl[2] = tbl[0];
    tbl[2].name = "recover";
    tbl[3].name = "len_over";
    tbl[3].b = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3].n = 3; tbl[3].err = 1; tbl[3].done = 0; tbl[3].nw = 0;
    tbl[3].w = '{32'h0, 32'h0};
    tbl[4].name = "len_zero";
    tbl[4].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4].n = 4; tbl[4].err = 0; tbl[4].done = 1; tbl[4].nw = 0;
    tbl[4].w = '{32'h0, 32'h0};

    tick(3);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h0000);
    chk("rst_dat", 32'(mem_dat), 32'h0000);
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_core_reset", 32'(core_reset), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(10);

    for (int i = 0; i < 5; i++) begin
      base = core_resets;
      for (int w = 0; w < tbl[i].nw; w++) sb.push_back(tbl[i].w[w]);
      for (int k = 0; k < tbl[i].n; k++) send_byte(tbl[i].b[k], 1'b1);
      tick(20);
      expect_state(tbl[i].name, tbl[i].err, tbl[i].done, base);
    end

    // stop bit low on the low byte of the first word
    base = core_resets;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    tick(30);
    expect_state("stop_low", 1'b1, 1'b0, base);

    // single-clock low glitch between bytes must not produce a byte
    base = core_resets;
    sb.push_back(32'h0000_1234);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(10);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h47, 1'b1);
    tick(20);
    expect_state("glitch", 1'b0, 1'b1, base);

    // in RUN, hold rises on the cycle the sync byte is accepted
    base = core_resets;
    seen = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        for (int c = 0; c < 60 && !seen; c++) begin
          @(negedge clk);
          if (dut.rx_valid) begin
            seen = 1;
            chk("run_sync_hold", 32'(core_hold), 32'd1);
          end
        end
      end
    join
    chk("run_sync_seen", 32'(seen), 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(20);
    expect_state("resync", 1'b0, 1'b1, base);

    // inter-byte timeout, then a clean restart from the base address
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    tick(40);
    chk("timeout_early_err", 32'(err), 32'd0);
    chk("timeout_early_hold", 32'(core_hold), 32'd1);
    tick(30);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_hold", 32'(core_hold), 32'd1);
    base = core_resets;
    sb.push_back(32'h0000_ABCD);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h79, 1'b1);
    tick(20);
    expect_state("after_timeout", 1'b0, 1'b1, base);

    // asynchronous reset while the loader waits in DATA_LO
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rst = 1'b1;
    #1;
    chk("midrst_hold", 32'(core_hold), 32'd1);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'h0000);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_core_reset", 32'(core_reset), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(60);
    chk("postrst_hold", 32'(core_hold), 32'd1);
    chk("postrst_err", 32'(err), 32'd0);
    base = core_resets;
    sb.push_back(32'h0000_1234);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h47, 1'b1);
    tick(20);
    expect_state("postrst_load", 1'b0, 1'b1, base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
